// File: rtl/spi_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package  : spi_arbiter_pkg
// Desc     : Shared widths, FSM encodings and helpers for the SPI arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package spi_arbiter_pkg;

  localparam int SPI_DW  = 32;
  localparam int SPI_NBW = 5;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_ISSUE = 2'b01;
  localparam logic [1:0] ST_BUSY  = 2'b10;
  localparam logic [1:0] ST_DONE  = 2'b11;

  typedef logic [1:0] arb_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : spi_arbiter_pkg
`default_nettype wire

// File: rtl/spi_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : spi_rr_pick
// Desc     : Combinational round-robin picker: first set request after 'last'.
// Revision : 1.0 - initial release
// ============================================================================
module spi_rr_pick
  import spi_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] onehot,
  output logic [IW-1:0]   idx,
  output logic            any
);

  logic [IW-1:0] cand;

  // Scan NREQ positions starting just after the previous owner, wrapping to 0.
  always_comb begin
    onehot = '0;
    idx    = '0;
    cand   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IW'((int'(last) + i) % NREQ);
      if ((onehot == '0) && req[cand]) begin
        onehot[cand] = 1'b1;
        idx          = cand;
      end
    end
  end

  assign any = |req;

endmodule : spi_rr_pick
`default_nettype wire

// File: rtl/spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_arbiter
// Desc     : Round-robin sharing of one SPI master between NREQ requesters,
//            one transaction per grant, with a per-phase watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module spi_arbiter
  import spi_arbiter_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic                    clk_in,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*SPI_DW-1:0]  req_mosi_data,
  input  logic [NREQ*SPI_NBW-1:0] req_nbits,
  output logic [NREQ-1:0]         req_done,
  output logic                    req_err,
  output logic [SPI_DW-1:0]       req_miso_data,
  output logic [NREQ-1:0]         grant,
  output logic [SPI_DW-1:0]       spi_mosi_data,
  output logic [SPI_NBW-1:0]      spi_nbits,
  output logic                    spi_request,
  input  logic                    spi_ready,
  input  logic [SPI_DW-1:0]       spi_miso_data
);

  localparam int IW  = idx_width(NREQ);
  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  arb_state_t         state_q,       state_d;
  logic [IW-1:0]      last_q,        last_d;
  logic [NREQ-1:0]    grant_q,       grant_d;
  logic               spi_request_q, spi_request_d;
  logic [SPI_DW-1:0]  spi_mosi_q,    spi_mosi_d;
  logic [SPI_NBW-1:0] spi_nbits_q,   spi_nbits_d;
  logic [NREQ-1:0]    req_done_q,    req_done_d;
  logic               req_err_q,     req_err_d;
  logic [SPI_DW-1:0]  req_miso_q,    req_miso_d;
  logic [WDW-1:0]     wd_q,          wd_d;

  logic [SPI_DW-1:0]  w_mosi  [NREQ];
  logic [SPI_NBW-1:0] w_nbits [NREQ];
  logic [NREQ-1:0]    w_pick_onehot;
  logic [IW-1:0]      w_pick_idx;
  logic               w_pick_any;
  logic               w_wd_expire;

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign w_mosi[i]  = req_mosi_data[SPI_DW*i +: SPI_DW];
    assign w_nbits[i] = req_nbits[SPI_NBW*i +: SPI_NBW];
  end

  spi_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req    (req_valid),
    .last   (last_q),
    .onehot (w_pick_onehot),
    .idx    (w_pick_idx),
    .any    (w_pick_any)
  );

  assign w_wd_expire = (TIMEOUT != 0) && (wd_q == WDW'(TIMEOUT - 1));

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    grant_d       = grant_q;
    spi_request_d = spi_request_q;
    spi_mosi_d    = spi_mosi_q;
    spi_nbits_d   = spi_nbits_q;
    req_done_d    = '0;
    req_err_d     = 1'b0;
    req_miso_d    = req_miso_q;
    wd_d          = '0;

    case (state_q)
      ST_IDLE: begin
        if (w_pick_any && spi_ready) begin
          grant_d       = w_pick_onehot;
          last_d        = w_pick_idx;
          spi_mosi_d    = w_mosi[w_pick_idx];
          spi_nbits_d   = w_nbits[w_pick_idx];
          spi_request_d = 1'b1;
          state_d       = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // A real handshake wins over a watchdog expiry landing on the same cycle.
        if (!spi_ready) begin
          spi_request_d = 1'b0;
          state_d       = ST_BUSY;
        end else if (w_wd_expire) begin
          spi_request_d = 1'b0;
          req_done_d    = grant_q;
          req_err_d     = 1'b1;
          grant_d       = '0;
          state_d       = ST_DONE;
        end else if (TIMEOUT != 0) begin
          wd_d = wd_q + WDW'(1);
        end
      end
      ST_BUSY: begin
        if (spi_ready) begin
          req_miso_d = spi_miso_data;
          req_done_d = grant_q;
          grant_d    = '0;
          state_d    = ST_DONE;
        end else if (w_wd_expire) begin
          spi_request_d = 1'b0;
          req_done_d    = grant_q;
          req_err_d     = 1'b1;
          grant_d       = '0;
          state_d       = ST_DONE;
        end else if (TIMEOUT != 0) begin
          wd_d = wd_q + WDW'(1);
        end
      end
      ST_DONE: begin
        grant_d       = '0;
        spi_request_d = 1'b0;
        state_d       = ST_IDLE;
      end
      default: begin
        grant_d       = '0;
        spi_request_d = 1'b0;
        state_d       = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      last_q        <= IW'(NREQ - 1);
      grant_q       <= '0;
      spi_request_q <= 1'b0;
      spi_mosi_q    <= '0;
      spi_nbits_q   <= '0;
      req_done_q    <= '0;
      req_err_q     <= 1'b0;
      req_miso_q    <= '0;
      wd_q          <= '0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      grant_q       <= grant_d;
      spi_request_q <= spi_request_d;
      spi_mosi_q    <= spi_mosi_d;
      spi_nbits_q   <= spi_nbits_d;
      req_done_q    <= req_done_d;
      req_err_q     <= req_err_d;
      req_miso_q    <= req_miso_d;
      wd_q          <= wd_d;
    end
  end

  assign grant         = grant_q;
  assign spi_request   = spi_request_q;
  assign spi_mosi_data = spi_mosi_q;
  assign spi_nbits     = spi_nbits_q;
  assign req_done      = req_done_q;
  assign req_err       = req_err_q;
  assign req_miso_data = req_miso_q;

endmodule : spi_arbiter
`default_nettype wire

// File: tb/tb_spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_arbiter
// Desc     : Directed, table-driven bench for spi_arbiter with a simple master model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_spi_arbiter;

  logic        clk_in = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [63:0] req_mosi_data;
  logic [9:0]  req_nbits;
  logic [1:0]  req_done;
  logic        req_err;
  logic [31:0] req_miso_data;
  logic [1:0]  grant;
  logic [31:0] spi_mosi_data;
  logic [4:0]  spi_nbits;
  logic        spi_request;
  logic        spi_ready;
  logic [31:0] spi_miso_data;

  logic        m_ready;
  bit          m_hang;
  bit          m_block;
  int          m_busy;
  logic [31:0] m_resp;

  int n_checks;
  int n_fail;

  assign spi_ready = m_ready && !m_block;

  always #5 clk_in = ~clk_in;

  spi_arbiter #(
    .NREQ    (2),
    .TIMEOUT (16)
  ) dut (
    .clk_in        (clk_in),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_mosi_data (req_mosi_data),
    .req_nbits     (req_nbits),
    .req_done      (req_done),
    .req_err       (req_err),
    .req_miso_data (req_miso_data),
    .grant         (grant),
    .spi_mosi_data (spi_mosi_data),
    .spi_nbits     (spi_nbits),
    .spi_request   (spi_request),
    .spi_ready     (spi_ready),
    .spi_miso_data (spi_miso_data)
  );

  // SPI master model: drops ready after seeing a request, holds busy m_busy cycles.
  initial begin
    m_ready       = 1'b1;
    spi_miso_data = '0;
    forever begin
      @(posedge clk_in);
      #1;
      if (m_hang) spi_miso_data = m_resp;
      if (spi_request && m_ready && !m_hang) begin
        m_ready = 1'b0;
        repeat (m_busy) @(posedge clk_in);
        #1;
        spi_miso_data = m_resp;
        m_ready       = 1'b1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 100000ns");
    $fatal(1, "global timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic wait_request(input string name);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_in);
      if (spi_request === 1'b1) return;
    end
    check({name, "_request_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_done(input string name);
    for (int c = 0; c < 60; c++) begin
      @(negedge clk_in);
      if (req_done !== 2'b00) return;
    end
    check({name, "_done_timeout"}, 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [1:0]  valid;
    logic [31:0] mosi0;
    logic [4:0]  nbits0;
    logic [31:0] mosi1;
    logic [4:0]  nbits1;
    logic [31:0] resp;
    int          busy;
    logic [1:0]  exp_grant;
    logic [31:0] exp_mosi;
    logic [4:0]  exp_nbits;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int cnt;

    n_checks  = 0;
    n_fail    = 0;
    m_hang    = 1'b0;
    m_block   = 1'b0;
    m_busy    = 2;
    m_resp    = '0;
    rst       = 1'b1;
    req_valid = '0;
    req_mosi_data = '0;
    req_nbits     = '0;

    // Round-robin pointer enters the table at 1 (after the 0,1,0,1 sequence).
    vecs[0] = '{2'b01, 32'h0000_8F00, 5'd15, 32'hAAAA_0001, 5'd7,  32'h0000_0033, 2, 2'b01, 32'h0000_8F00, 5'd15};
    vecs[1] = '{2'b11, 32'h1111_0000, 5'd31, 32'h2222_0000, 5'd8,  32'h1234_5678, 1, 2'b10, 32'h2222_0000, 5'd8};
    vecs[2] = '{2'b11, 32'h3333_0003, 5'd3,  32'h4444_0004, 5'd4,  32'hCAFE_F00D, 3, 2'b01, 32'h3333_0003, 5'd3};
    vecs[3] = '{2'b11, 32'h5555_5555, 5'd0,  32'h6666_6666, 5'd31, 32'hDEAD_BEEF, 1, 2'b10, 32'h6666_6666, 5'd31};
    vecs[4] = '{2'b10, 32'h7777_0000, 5'd1,  32'h8888_0001, 5'd16, 32'h0000_FFFF, 2, 2'b10, 32'h8888_0001, 5'd16};
    vecs[5] = '{2'b01, 32'h9999_9999, 5'd23, 32'h0000_0000, 5'd0,  32'hFFFF_0000, 2, 2'b01, 32'h9999_9999, 5'd23};
    vecs[6] = '{2'b01, 32'hABCD_EF01, 5'd12, 32'h1357_9BDF, 5'd5,  32'h0F0F_0F0F, 4, 2'b01, 32'hABCD_EF01, 5'd12};

    repeat (3) @(negedge clk_in);
    check("rst_grant",       {30'd0, grant},       32'd0);
    check("rst_spi_request", {31'd0, spi_request}, 32'd0);
    check("rst_req_done",    {30'd0, req_done},    32'd0);
    check("rst_req_err",     {31'd0, req_err},     32'd0);
    check("rst_req_miso",    req_miso_data,        32'd0);
    check("rst_spi_mosi",    spi_mosi_data,        32'd0);
    check("rst_spi_nbits",   {27'd0, spi_nbits},   32'd0);
    rst = 1'b0;
    @(negedge clk_in);

    // Two requesters raised together and held: alternate grants starting at 0.
    req_mosi_data = {32'hB1B1_1111, 32'hA0A0_0000};
    req_nbits     = {5'd20, 5'd10};
    req_valid     = 2'b11;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] eg;
      eg     = (k % 2 == 0) ? 2'b01 : 2'b10;
      m_resp = 32'h100 + k;
      wait_request($sformatf("rr%0d", k));
      check($sformatf("rr%0d_grant", k), {30'd0, grant}, {30'd0, eg});
      check($sformatf("rr%0d_mosi", k), spi_mosi_data, (k % 2 == 0) ? 32'hA0A0_0000 : 32'hB1B1_1111);
      check($sformatf("rr%0d_nbits", k), {27'd0, spi_nbits}, (k % 2 == 0) ? 32'd10 : 32'd20);
      wait_done($sformatf("rr%0d", k));
      check($sformatf("rr%0d_done", k), {30'd0, req_done}, {30'd0, eg});
      check($sformatf("rr%0d_miso", k), req_miso_data, 32'h100 + k);
    end
    req_valid = 2'b00;
    @(negedge clk_in);

    for (int i = 0; i < 7; i++) begin
      @(negedge clk_in);
      m_busy        = vecs[i].busy;
      m_resp        = vecs[i].resp;
      req_mosi_data = {vecs[i].mosi1, vecs[i].mosi0};
      req_nbits     = {vecs[i].nbits1, vecs[i].nbits0};
      req_valid     = vecs[i].valid;
      @(negedge clk_in);
      check($sformatf("v%0d_request", i), {31'd0, spi_request}, 32'd1);
      check($sformatf("v%0d_grant", i),   {30'd0, grant}, {30'd0, vecs[i].exp_grant});
      check($sformatf("v%0d_mosi", i),    spi_mosi_data, vecs[i].exp_mosi);
      check($sformatf("v%0d_nbits", i),   {27'd0, spi_nbits}, {27'd0, vecs[i].exp_nbits});
      wait_done($sformatf("v%0d", i));
      check($sformatf("v%0d_done", i),    {30'd0, req_done}, {30'd0, vecs[i].exp_grant});
      check($sformatf("v%0d_err", i),     {31'd0, req_err}, 32'd0);
      check($sformatf("v%0d_miso", i),    req_miso_data, vecs[i].resp);
      check($sformatf("v%0d_grant_done", i), {30'd0, grant}, 32'd0);
      check($sformatf("v%0d_mosi_held", i),  spi_mosi_data, vecs[i].exp_mosi);
      req_valid = 2'b00;
      @(negedge clk_in);
      check($sformatf("v%0d_done_pulse", i), {30'd0, req_done}, 32'd0);
    end

    // Master not ready while idle: nothing granted until spi_ready rises.
    m_block       = 1'b1;
    m_busy        = 2;
    m_resp        = 32'h0BAD_F00D;
    req_mosi_data = {32'h0, 32'hC0DE_0003};
    req_nbits     = {5'd0, 5'd9};
    req_valid     = 2'b01;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_in);
      check($sformatf("blk%0d_grant", c),   {30'd0, grant}, 32'd0);
      check($sformatf("blk%0d_request", c), {31'd0, spi_request}, 32'd0);
    end
    m_block = 1'b0;
    @(negedge clk_in);
    check("blk_grant_after_ready",   {30'd0, grant}, 32'd1);
    check("blk_request_after_ready", {31'd0, spi_request}, 32'd1);
    wait_done("blk");
    check("blk_done", {30'd0, req_done}, 32'd1);
    check("blk_miso", req_miso_data, 32'h0BAD_F00D);
    req_valid = 2'b00;
    @(negedge clk_in);

    // Watchdog: master never acknowledges, 16 ISSUE cycles then abort.
    m_hang        = 1'b1;
    m_resp        = 32'hBAD0_BAD0;
    req_mosi_data = {32'hFEED_0001, 32'h0};
    req_nbits     = {5'd31, 5'd0};
    @(negedge clk_in);
    req_valid = 2'b10;
    wait_request("wd");
    cnt = 0;
    for (int c = 0; c < 40 && spi_request === 1'b1; c++) begin
      cnt++;
      @(negedge clk_in);
    end
    check("wd_issue_cycles", cnt, 32'd16);
    check("wd_request_low",  {31'd0, spi_request}, 32'd0);
    check("wd_done",         {30'd0, req_done}, 32'd2);
    check("wd_err",          {31'd0, req_err}, 32'd1);
    check("wd_miso_kept",    req_miso_data, 32'h0BAD_F00D);
    check("wd_grant_clear",  {30'd0, grant}, 32'd0);
    req_valid = 2'b00;
    m_hang    = 1'b0;
    @(negedge clk_in);
    check("wd_err_pulse",  {31'd0, req_err}, 32'd0);
    check("wd_done_pulse", {30'd0, req_done}, 32'd0);
    @(negedge clk_in);

    // Reset during BUSY: outputs clear at once, requester 0 wins afterwards.
    m_busy        = 8;
    m_resp        = 32'h5555_AAAA;
    req_mosi_data = {32'h2000_0002, 32'h1000_0001};
    req_nbits     = {5'd2, 5'd1};
    req_valid     = 2'b01;
    wait_request("rst_mid");
    repeat (3) @(negedge clk_in);
    check("rst_mid_grant_before", {30'd0, grant}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_request", {31'd0, spi_request}, 32'd0);
    check("rst_mid_grant",   {30'd0, grant}, 32'd0);
    check("rst_mid_done",    {30'd0, req_done}, 32'd0);
    check("rst_mid_miso",    req_miso_data, 32'd0);
    m_resp    = 32'h6666_1234;
    m_busy    = 2;
    req_valid = 2'b11;
    @(negedge clk_in);
    rst = 1'b0;
    wait_request("rst_after");
    check("rst_after_grant", {30'd0, grant}, 32'd1);
    check("rst_after_mosi",  spi_mosi_data, 32'h1000_0001);
    wait_done("rst_after");
    check("rst_after_done", {30'd0, req_done}, 32'd1);
    check("rst_after_miso", req_miso_data, 32'h6666_1234);
    m_busy    = 5;
    m_resp    = 32'h7777_4321;
    req_valid = 2'b10;

    // Requester 1 drops mid-BUSY: its transaction still completes, then 0 is served.
    wait_request("drop");
    check("drop_grant", {30'd0, grant}, 32'd2);
    repeat (2) @(negedge clk_in);
    req_valid = 2'b01;
    wait_done("drop");
    check("drop_done", {30'd0, req_done}, 32'd2);
    check("drop_err",  {31'd0, req_err}, 32'd0);
    check("drop_miso", req_miso_data, 32'h7777_4321);
    m_busy = 2;
    m_resp = 32'h8888_0000;
    wait_request("drop_next");
    check("drop_next_grant", {30'd0, grant}, 32'd1);
    check("drop_next_mosi",  spi_mosi_data, 32'h1000_0001);
    wait_done("drop_next");
    check("drop_next_done", {30'd0, req_done}, 32'd1);
    check("drop_next_miso", req_miso_data, 32'h8888_0000);
    req_valid = 2'b00;
    repeat (3) @(negedge clk_in);
    check("final_idle_grant", {30'd0, grant}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_spi_arbiter
`default_nettype wire
